// File: rtl/bt_frame_ctrl.sv
// ---------------------------------------------------------------------------
// bt_frame_ctrl
//
// Frame controller for the Bluetooth UART link. Owns the UART receiver's
// reset line and assembles received bytes into command frames of the form
//    HEADER, CMD, LEN, PAYLOAD[LEN], CSUM
// where CSUM is the XOR of CMD, LEN and every payload byte. Checked frames
// are presented to the game command decoder through a valid/ready handshake.
//
// Ports
//    clk            system clock
//    rst            synchronous active-high reset
//    en             controller enable; low holds the receiver in reset and
//                   the FSM in IDLE
//    rx_data        received byte, qualified by rx_valid
//    rx_valid       one-cycle strobe per received byte
//    rx_rst         active-high reset to the UART receiver
//    frame_valid    checked frame available
//    frame_ready    consumer accepts the frame
//    frame_cmd      command byte of the held frame
//    frame_len      payload length of the held frame
//    frame_payload  payload byte i at [8i+7:8i], unused bytes zero
//    err_csum       one-cycle pulse, checksum mismatch
//    err_len        one-cycle pulse, length above MAX_LEN
//    err_timeout    one-cycle pulse, inter-byte timeout inside a frame
//    err_overrun    one-cycle pulse, byte arrived while a frame was held
//    busy           FSM not in IDLE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | hunting for the header byte
// CMD   | waiting for the command byte
// LEN   | waiting for the length byte
// DATA  | collecting payload bytes
// CSUM  | waiting for the checksum byte
// HOLD  | checked frame presented, waiting for frame_ready
// ---------------------------------------------------------------------------
module bt_frame_ctrl #(
    parameter logic [7:0] HEADER      = 8'hAA,
    parameter int         MAX_LEN     = 4,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_rst,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [7:0]             frame_cmd,
    output logic [2:0]             frame_len,
    output logic [8*MAX_LEN-1:0]   frame_payload,
    output logic                   err_csum,
    output logic                   err_len,
    output logic                   err_timeout,
    output logic                   err_overrun,
    output logic                   busy
);

    localparam int                CNT_W  = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_TC = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_HOLD = 3'd5
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [7:0]             csum_q;
    logic [7:0]             cmd_q;
    logic [2:0]             len_q;
    logic [2:0]             idx_q;
    logic [8*MAX_LEN-1:0]   pay_q;

    logic                   rx_rst_q;
    logic                   frame_valid_q;
    logic [7:0]             frame_cmd_q;
    logic [2:0]             frame_len_q;
    logic [8*MAX_LEN-1:0]   frame_payload_q;
    logic                   err_csum_q;
    logic                   err_len_q;
    logic                   err_timeout_q;
    logic                   err_overrun_q;
    logic                   busy_q;

    logic                   in_frame;
    logic                   timeout_fire;

    assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);

    // A byte landing in the expiry cycle wins over the timeout.
    assign timeout_fire = en && in_frame && !rx_valid && (cnt_q == CNT_TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            csum_q          <= '0;
            cmd_q           <= '0;
            len_q           <= '0;
            idx_q           <= '0;
            pay_q           <= '0;
            rx_rst_q        <= 1'b1;
            frame_valid_q   <= 1'b0;
            frame_cmd_q     <= '0;
            frame_len_q     <= '0;
            frame_payload_q <= '0;
            err_csum_q      <= 1'b0;
            err_len_q       <= 1'b0;
            err_timeout_q   <= 1'b0;
            err_overrun_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            err_csum_q    <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            rx_rst_q      <= ~en | timeout_fire;

            if (!en) begin
                // Disabling silently abandons any partial or held frame.
                state_q       <= S_IDLE;
                cnt_q         <= '0;
                frame_valid_q <= 1'b0;
                busy_q        <= 1'b0;
            end else if (timeout_fire) begin
                state_q       <= S_IDLE;
                cnt_q         <= '0;
                err_timeout_q <= 1'b1;
                busy_q        <= 1'b0;
            end else begin
                if (rx_valid || !in_frame) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end

                case (state_q)
                    S_IDLE: begin
                        if (rx_valid && (rx_data == HEADER)) begin
                            state_q <= S_CMD;
                            busy_q  <= 1'b1;
                        end
                    end

                    S_CMD: begin
                        if (rx_valid) begin
                            cmd_q   <= rx_data;
                            csum_q  <= rx_data;
                            state_q <= S_LEN;
                        end
                    end

                    S_LEN: begin
                        if (rx_valid) begin
                            csum_q <= csum_q ^ rx_data;
                            if (rx_data > 8'(MAX_LEN)) begin
                                err_len_q <= 1'b1;
                                state_q   <= S_IDLE;
                                busy_q    <= 1'b0;
                            end else begin
                                // Payload is cleared for zero-length frames too,
                                // so unused bytes always read back as zero.
                                len_q   <= rx_data[2:0];
                                idx_q   <= '0;
                                pay_q   <= '0;
                                state_q <= (rx_data == 8'd0) ? S_CSUM : S_DATA;
                            end
                        end
                    end

                    S_DATA: begin
                        if (rx_valid) begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                if (idx_q == 3'(i)) begin
                                    pay_q[8*i +: 8] <= rx_data;
                                end
                            end
                            csum_q <= csum_q ^ rx_data;
                            idx_q  <= idx_q + 3'd1;
                            if (idx_q == (len_q - 3'd1)) begin
                                state_q <= S_CSUM;
                            end
                        end
                    end

                    S_CSUM: begin
                        if (rx_valid) begin
                            if (rx_data == csum_q) begin
                                // Outputs only change on a fully checked frame.
                                frame_cmd_q     <= cmd_q;
                                frame_len_q     <= len_q;
                                frame_payload_q <= pay_q;
                                frame_valid_q   <= 1'b1;
                                state_q         <= S_HOLD;
                            end else begin
                                err_csum_q <= 1'b1;
                                state_q    <= S_IDLE;
                                busy_q     <= 1'b0;
                            end
                        end
                    end

                    S_HOLD: begin
                        // A byte here is dropped even if the frame is taken
                        // in the same cycle.
                        if (rx_valid) begin
                            err_overrun_q <= 1'b1;
                        end
                        if (frame_ready) begin
                            frame_valid_q <= 1'b0;
                            state_q       <= S_IDLE;
                            busy_q        <= 1'b0;
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_rst        = rx_rst_q;
    assign frame_valid   = frame_valid_q;
    assign frame_cmd     = frame_cmd_q;
    assign frame_len     = frame_len_q;
    assign frame_payload = frame_payload_q;
    assign err_csum      = err_csum_q;
    assign err_len       = err_len_q;
    assign err_timeout   = err_timeout_q;
    assign err_overrun   = err_overrun_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_bt_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bt_frame_ctrl
//
// Drives bt_frame_ctrl with directed frames and then random traffic. The
// reference model keeps the bytes received since the header in a queue and
// judges the frame from its length field and XOR, counting silent cycles
// for the timeout. Every cycle all DUT outputs are compared to the model.
// ---------------------------------------------------------------------------
module tb_bt_frame_ctrl;

    localparam int         MAX_LEN     = 4;
    localparam int         TIMEOUT_CYC = 20;
    localparam logic [7:0] HEADER      = 8'hAA;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_rst;
    logic                 frame_valid;
    logic                 frame_ready;
    logic [7:0]           frame_cmd;
    logic [2:0]           frame_len;
    logic [8*MAX_LEN-1:0] frame_payload;
    logic                 err_csum;
    logic                 err_len;
    logic                 err_timeout;
    logic                 err_overrun;
    logic                 busy;

    bt_frame_ctrl #(
        .HEADER      (HEADER),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_rst        (rx_rst),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .frame_cmd     (frame_cmd),
        .frame_len     (frame_len),
        .frame_payload (frame_payload),
        .err_csum      (err_csum),
        .err_len       (err_len),
        .err_timeout   (err_timeout),
        .err_overrun   (err_overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]           mq[$];
    bit                   m_coll;
    bit                   m_hold;
    int                   m_silent;
    logic                 e_fv, e_busy, e_rxrst;
    logic                 e_csum, e_len, e_to, e_ovr;
    logic [7:0]           e_cmd;
    logic [2:0]           e_flen;
    logic [8*MAX_LEN-1:0] e_pay;

    task automatic model_step(input logic r, input logic e, input logic v,
                              input logic [7:0] d, input logic rdy);
        logic [7:0] x;
        e_csum = 1'b0; e_len = 1'b0; e_to = 1'b0; e_ovr = 1'b0;
        if (r) begin
            m_coll = 0; m_hold = 0; mq.delete();
            e_cmd = '0; e_flen = '0; e_pay = '0;
            e_fv = 1'b0; e_busy = 1'b0; e_rxrst = 1'b1;
            return;
        end
        e_rxrst = !e;
        if (!e) begin
            m_coll = 0; m_hold = 0; mq.delete();
            e_fv = 1'b0; e_busy = 1'b0;
            return;
        end
        if (m_hold) begin
            if (v) e_ovr = 1'b1;
            if (rdy) m_hold = 0;
        end else if (m_coll) begin
            if (v) begin
                mq.push_back(d);
                m_silent = 0;
                if (mq.size() == 3 && int'(mq[2]) > MAX_LEN) begin
                    e_len = 1'b1;
                    m_coll = 0;
                end else if (mq.size() >= 3 && mq.size() == 4 + int'(mq[2])) begin
                    x = 8'h00;
                    for (int i = 1; i < mq.size() - 1; i++) x ^= mq[i];
                    if (x == mq[mq.size()-1]) begin
                        m_hold = 1;
                        e_cmd  = mq[1];
                        e_flen = mq[2][2:0];
                        e_pay  = '0;
                        for (int i = 0; i < int'(mq[2]); i++) e_pay[8*i +: 8] = mq[3+i];
                    end else begin
                        e_csum = 1'b1;
                    end
                    m_coll = 0;
                end
            end else begin
                m_silent++;
                if (m_silent == TIMEOUT_CYC) begin
                    e_to = 1'b1; e_rxrst = 1'b1; m_coll = 0;
                end
            end
        end else if (v && d == HEADER) begin
            m_coll = 1;
            mq.delete();
            mq.push_back(d);
            m_silent = 0;
        end
        e_fv   = m_hold;
        e_busy = m_coll || m_hold;
    endtask

    // ---------------- stimulus helpers ----------------
    bit                   rnd_rdy = 0;
    logic [7:0]           txq[$];
    int                   frames = 0;
    int                   n_csum = 0, n_len = 0, n_to = 0, n_ovr = 0;
    logic                 fv_prev = 1'b0;
    logic [7:0]           cap_cmd;
    logic [2:0]           cap_len;
    logic [8*MAX_LEN-1:0] cap_pay;

    task automatic tick(input logic v, input logic [7:0] d);
        if (rnd_rdy) frame_ready = ($urandom_range(0, 2) != 0);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        model_step(rst, en, v, d, frame_ready);
        #1;
        check("frame_valid", 64'(frame_valid), 64'(e_fv));
        check("busy", 64'(busy), 64'(e_busy));
        check("rx_rst", 64'(rx_rst), 64'(e_rxrst));
        check("err_csum", 64'(err_csum), 64'(e_csum));
        check("err_len", 64'(err_len), 64'(e_len));
        check("err_timeout", 64'(err_timeout), 64'(e_to));
        check("err_overrun", 64'(err_overrun), 64'(e_ovr));
        check("frame_cmd", 64'(frame_cmd), 64'(e_cmd));
        check("frame_len", 64'(frame_len), 64'(e_flen));
        check("frame_payload", 64'(frame_payload), 64'(e_pay));
        if (frame_valid && !fv_prev) begin
            frames++;
            cap_cmd = frame_cmd; cap_len = frame_len; cap_pay = frame_payload;
        end
        fv_prev = frame_valid;
        if (err_csum)    n_csum++;
        if (err_len)     n_len++;
        if (err_timeout) n_to++;
        if (err_overrun) n_ovr++;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    task automatic send_txq(input int maxgap);
        foreach (txq[i]) begin
            idle($urandom_range(0, maxgap));
            tick(1'b1, txq[i]);
        end
    endtask

    task automatic build_frame(input logic [7:0] cmd, input int len, input bit bad);
        logic [7:0] x, b;
        txq.delete();
        txq.push_back(HEADER);
        txq.push_back(cmd);
        txq.push_back(8'(len));
        x = cmd ^ 8'(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            txq.push_back(b);
            x ^= b;
        end
        if (bad) x = ~x;
        txq.push_back(x);
    endtask

    // ---------------- test sequence ----------------
    int f0, c0, l0, t0, o0;

    initial begin
        rst = 1'b1; en = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; frame_ready = 1'b1;
        idle(3);
        check("rst_cmd", 64'(frame_cmd), 64'h0);
        check("rst_payload", 64'(frame_payload), 64'h0);
        check("rst_rx_rst", 64'(rx_rst), 64'h1);
        rst = 1'b0;
        idle(2);

        // good frame, consumer always ready
        f0 = frames;
        txq = {8'hAA, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65};
        send_txq(0);
        idle(3);
        check("t1_frames", 64'(frames - f0), 64'd1);
        check("t1_cmd", 64'(cap_cmd), 64'h10);
        check("t1_len", 64'(cap_len), 64'd2);
        check("t1_payload", 64'(cap_pay), 64'h0000_4433);

        // bad checksum, then a good frame
        f0 = frames; c0 = n_csum;
        txq = {8'hAA, 8'h10, 8'h02, 8'h33, 8'h44, 8'h66};
        send_txq(1);
        idle(2);
        check("t2_csum_err", 64'(n_csum - c0), 64'd1);
        check("t2_no_frame", 64'(frames - f0), 64'd0);
        txq = {8'hAA, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65};
        send_txq(1);
        idle(2);
        check("t2_next_frame", 64'(frames - f0), 64'd1);

        // oversize length, trailing bytes ignored
        l0 = n_len; f0 = frames;
        txq = {8'hAA, 8'h05, 8'h07, 8'h33, 8'h44};
        send_txq(0);
        idle(2);
        check("t3_len_err", 64'(n_len - l0), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);

        // silence past the timeout
        t0 = n_to;
        txq = {8'hAA, 8'h20};
        send_txq(0);
        idle(TIMEOUT_CYC + 3);
        check("t4_timeout", 64'(n_to - t0), 64'd1);

        // byte in the expiry cycle is taken, no timeout
        t0 = n_to; f0 = frames;
        txq = {8'hAA, 8'h20};
        send_txq(0);
        idle(TIMEOUT_CYC - 1);
        tick(1'b1, 8'h00);
        idle(TIMEOUT_CYC - 1);
        tick(1'b1, 8'h20);
        idle(2);
        check("t4_no_timeout", 64'(n_to - t0), 64'd0);
        check("t4_frame", 64'(frames - f0), 64'd1);

        // held zero-length frame, overrun, then release
        frame_ready = 1'b0; o0 = n_ovr;
        txq = {8'hAA, 8'h01, 8'h00, 8'h01};
        send_txq(0);
        idle(3);
        tick(1'b1, 8'h55);
        idle(2);
        check("t5_overrun", 64'(n_ovr - o0), 64'd1);
        check("t5_held_cmd", 64'(frame_cmd), 64'h01);
        frame_ready = 1'b1;
        tick(1'b1, 8'h77);
        idle(1);
        check("t5_released", 64'(frame_valid), 64'd0);

        // overrun in the same cycle as acceptance, then back-to-back header
        frame_ready = 1'b0;
        txq = {8'hAA, 8'h03, 8'h00, 8'h03};
        send_txq(0);
        frame_ready = 1'b1;
        tick(1'b1, 8'h99);
        frame_ready = 1'b0;
        txq = {8'hAA, 8'h04, 8'h00, 8'h04};
        send_txq(0);
        idle(2);
        frame_ready = 1'b1;
        idle(2);

        // enable dropped during DATA and during HOLD
        txq = {8'hAA, 8'h11, 8'h03, 8'h01};
        send_txq(0);
        en = 1'b0;
        idle(3);
        en = 1'b1;
        idle(2);
        frame_ready = 1'b0;
        txq = {8'hAA, 8'h01, 8'h00, 8'h01};
        send_txq(0);
        idle(2);
        en = 1'b0;
        idle(2);
        en = 1'b1;
        frame_ready = 1'b1;
        idle(2);

        // reset mid-frame
        txq = {8'hAA, 8'h12, 8'h02, 8'h05};
        send_txq(0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3);

        // random traffic
        rnd_rdy = 1;
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = $urandom_range(0, 13);
            if (kind <= 5) begin
                build_frame(8'($urandom), $urandom_range(0, MAX_LEN), 0);
                send_txq(2);
            end else if (kind <= 7) begin
                build_frame(8'($urandom), $urandom_range(0, MAX_LEN), 1);
                send_txq(2);
            end else if (kind == 8) begin
                build_frame(8'($urandom), $urandom_range(MAX_LEN + 1, 7), 0);
                send_txq(1);
            end else if (kind == 9) begin
                tick(1'b1, 8'($urandom));
            end else if (kind == 10) begin
                build_frame(8'($urandom), $urandom_range(1, MAX_LEN), 0);
                void'(txq.pop_back());
                send_txq(1);
                idle(TIMEOUT_CYC - 2 + $urandom_range(0, 4));
            end else if (kind == 11) begin
                en = 1'b0;
                idle($urandom_range(1, 3));
                en = 1'b1;
            end else if (kind == 12) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end else begin
                idle($urandom_range(0, 5));
            end
        end
        rnd_rdy = 0;
        frame_ready = 1'b1;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bt_frame_ctrl.md
# bt_frame_ctrl

Frame controller for the Bluetooth UART link. It sequences the byte receiver by owning its reset line, and assembles the received bytes into command frames. Each frame is header, command, length, payload and XOR checksum. The controller checks every frame and hands valid ones to game logic through a valid/ready handshake. It sits between the UART receiver (byte strobe interface) and the game command decoder.

## Interface
- `HEADER`, 8'hAA, start-of-frame byte.
- `MAX_LEN`, 4, maximum payload bytes (1..7).
- `TIMEOUT_CYC`, 100000, maximum clk cycles between bytes inside a frame (≥2).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  controller enable; 0 holds receiver in reset and FSM in IDLE.
- `rx_data`  in  8  received byte, valid only with `rx_valid`.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `rx_rst`  out  1  reset to UART receiver, active-high.
- `frame_valid`  out  1  complete checked frame available.
- `frame_ready`  in  1  consumer accepts frame.
- `frame_cmd`  out  8  command byte.
- `frame_len`  out  3  payload length.
- `frame_payload`  out  8*MAX_LEN  payload byte i at [8i+7:8i]; unused bytes 0.
- `err_csum`  out  1  one-cycle pulse, checksum mismatch.
- `err_len`  out  1  one-cycle pulse, length > MAX_LEN.
- `err_timeout`  out  1  one-cycle pulse, inter-byte timeout.
- `err_overrun`  out  1  one-cycle pulse, byte arrived while frame held.
- `busy`  out  1  FSM not in IDLE.

## Operation
- States: IDLE, CMD, LEN, DATA, CSUM, HOLD.
- IDLE: on `rx_valid` with `rx_data==HEADER`, go to CMD. Any other byte is ignored with no error.
- CMD: on the byte, store `frame_cmd`, set csum=byte, go to LEN.
- LEN:
  - byte > MAX_LEN: pulse `err_len`, go to IDLE.
  - byte = 0: go to CSUM.
  - otherwise: store len, clear payload and byte index, go to DATA.
  - csum ^= byte in all three cases.
- DATA: store byte at current index, csum ^= byte, increment index. After the len-th byte, go to CSUM.
- CSUM:
  - byte == csum: go to HOLD.
  - otherwise: pulse `err_csum`, go to IDLE. Frame outputs are not updated on failure.
- HOLD: `frame_valid`=1 and all frame outputs are stable. When `frame_ready`=1, go to IDLE.
- Overrun: a byte arriving in HOLD is dropped and `err_overrun` pulses. This also applies when it arrives in the same cycle as `frame_ready`.
- Timeout counter:
  - Cleared on every `rx_valid`, and held at 0 in IDLE and HOLD.
  - Increments in CMD/LEN/DATA/CSUM. Width is clog2(TIMEOUT_CYC).
  - On reaching TIMEOUT_CYC-1 without a byte: pulse `err_timeout`, pulse `rx_rst` for 1 cycle, go to IDLE.
  - A byte in the same cycle as expiry wins: it is processed and the counter clears.
- `rx_rst` is registered: `rx_rst` <= `rst` | ~`en` | timeout_fire.
- `en`=0 in any state: go to IDLE on the next edge and discard any partial or held frame. `frame_valid` drops and no error pulses.
- Bytes are evaluated against the current state only. One byte is consumed per `rx_valid`.

## Timing
- Reset values: `frame_valid`=0, `frame_cmd`=0, `frame_len`=0, `frame_payload`=0, all err_*=0, `busy`=0, `rx_rst`=1, state IDLE, counter 0.
- All outputs are registered.
- `frame_valid` rises on the edge after the clk edge sampling the checksum byte's `rx_valid` (1-cycle latency).
- `frame_valid` falls on the edge after `frame_ready` is sampled high. With `frame_ready` held high, a frame is valid for exactly 1 cycle.
- Error pulses assert the cycle after the offending byte or expiry, for exactly 1 cycle.
- `busy` is 1 from the cycle after the header is accepted until the return to IDLE.
- Back-to-back: a header strobed the cycle after HOLD exits is accepted.
- Reset mid-frame: IDLE on the next edge, `rx_rst`=1 the following cycle.

## Test plan
- Frame AA 10 02 33 44 (csum 10^02^33^44=65) 65, `frame_ready`=1 -> one-cycle `frame_valid` with cmd=10, len=2, payload=32'h0000_4433, no errors.
- Same frame with csum 66 -> `err_csum` pulse, no `frame_valid`. A following valid frame is accepted normally.
- AA 05 07 (len 7 > 4) -> `err_len` pulse, return to IDLE. Next bytes 33 44 are ignored until AA.
- AA 20, then silence for TIMEOUT_CYC cycles -> `err_timeout` and `rx_rst` each pulse 1 cycle, `busy`=0. Also: a byte in the expiry cycle is processed with no timeout.
- Valid len-0 frame AA 01 00 01 with `frame_ready`=0 -> `frame_valid` held with stable outputs. Byte 55 strobed -> `err_overrun`, frame unchanged. Raising ready clears `frame_valid` next cycle.
- `en` dropped during DATA and during HOLD -> IDLE next cycle, `frame_valid`=0, `rx_rst`=1 while `en`=0. `rst` mid-frame -> all reset values.
